// File: rtl/tick_pwm_generator.sv
// Tick-driven PWM generator with a one-entry config buffer.
// Period and duty updates are applied only at period boundaries.
module tick_pwm_generator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             period_end,
  output logic             running
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] pper_q, pper_d;
  logic [WIDTH-1:0] pduty_q, pduty_d;
  logic             pfull_q, pfull_d;
  logic             loaded_q, loaded_d;
  logic             pwm_q, pwm_d;
  logic             pend_q, pend_d;

  logic             accept;
  logic             apply;
  logic             wrap;

  assign accept = cfg_valid && !pfull_q;
  assign wrap   = (phase_q == per_q - ONE);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    per_d    = per_q;
    duty_d   = duty_q;
    pper_d   = pper_q;
    pduty_d  = pduty_q;
    pfull_d  = pfull_q;
    loaded_d = loaded_q;
    pend_d   = 1'b0;
    apply    = 1'b0;

    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        if (pfull_q) begin
          apply    = 1'b1;
          loaded_d = 1'b1;
        end
        if (enable && loaded_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          phase_d = '0;
        end else if (tick) begin
          if (wrap) begin
            phase_d = '0;
            pend_d  = 1'b1;
            apply   = pfull_q;
          end else begin
            phase_d = phase_q + ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (apply) begin
      per_d   = pper_q;
      duty_d  = pduty_q;
      pfull_d = 1'b0;
    end

    // accept is gated by !pfull_q, so it never collides with apply
    if (accept) begin
      pper_d  = (cfg_period == '0) ? ONE : cfg_period;
      pduty_d = cfg_duty;
      pfull_d = 1'b1;
    end

    pwm_d = (state_d == RUN) && (phase_d < duty_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      per_q    <= ONE;
      duty_q   <= '0;
      pper_q   <= ONE;
      pduty_q  <= '0;
      pfull_q  <= 1'b0;
      loaded_q <= 1'b0;
      pwm_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      per_q    <= per_d;
      duty_q   <= duty_d;
      pper_q   <= pper_d;
      pduty_q  <= pduty_d;
      pfull_q  <= pfull_d;
      loaded_q <= loaded_d;
      pwm_q    <= pwm_d;
      pend_q   <= pend_d;
    end
  end

  assign cfg_ready  = !pfull_q;
  assign pwm_out    = pwm_q;
  assign period_end = pend_q;
  assign running    = (state_q == RUN);

endmodule

// File: tb/tb_tick_pwm_generator.sv
// Scoreboard bench for tick_pwm_generator.
// Expected tuple per cycle: {pwm_out, period_end, running, cfg_ready}.
module tb_tick_pwm_generator;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick = 1'b0;
  logic         enable = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] cfg_duty = '0;
  logic         cfg_ready;
  logic         pwm_out;
  logic         period_end;
  logic         running;

  tick_pwm_generator #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .pwm_out    (pwm_out),
    .period_end (period_end),
    .running    (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] exp;
    int         id;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   nstep = 0;
  bit   done = 1'b0;
  logic rst_prev = 1'b0;
  bit   fell;
  exp_t cur;
  logic [3:0] got;

  bit         tp[12];
  logic [3:0] ep[12];

  task automatic step(input logic t, input logic en,
                      input logic v, input logic [W-1:0] per,
                      input logic [W-1:0] dt,
                      input logic [3:0] e);
    tick       = t;
    enable     = en;
    cfg_valid  = v;
    cfg_period = per;
    cfg_duty   = dt;
    @(posedge clk);
    #1;
    sbq.push_back('{exp: e, id: nstep});
    nstep++;
  endtask

  task automatic run(input logic t, input logic [3:0] e);
    step(t, 1'b1, 1'b0, '0, '0, e);
  endtask

  always @(negedge clk or negedge rst_n) begin
    fell = rst_prev && !rst_n;
    rst_prev = rst_n;
    if (fell) begin
      #1;
      got = {pwm_out, period_end, running, cfg_ready};
      tests++;
      if (got !== 4'b0001) begin
        fails++;
        $display("FAIL async_reset got=%b want=0001", got);
      end
    end else if (sbq.size() > 0) begin
      cur = sbq.pop_front();
      got = {pwm_out, period_end, running, cfg_ready};
      tests++;
      if (got !== cur.exp) begin
        fails++;
        $display("FAIL step%0d got=%b want=%b",
                 cur.id, got, cur.exp);
      end
    end
    if (done && sbq.size() == 0) begin
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    tp = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    ep = '{4'b1011, 4'b1011, 4'b0011, 4'b0011,
           4'b0011, 4'b0011, 4'b0011, 4'b0011,
           4'b0011, 4'b0011, 4'b0011, 4'b1111};

    for (int i = 0; i < 4; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom),
           W'($urandom), W'($urandom), 4'b0001);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom), 1'b1, 1'b0, '0, '0, 4'b0001);
    end

    step(1'b0, 1'b0, 1'b1, 16'd4, 16'd1, 4'b0000);
    step(1'b0, 1'b0, 1'b0, '0, '0, 4'b0001);
    run(1'b1, 4'b1011);
    for (int p = 0; p < 2; p++) begin
      run(1'b1, 4'b0011);
      run(1'b1, 4'b0011);
      run(1'b1, 4'b0011);
      run(1'b1, 4'b1111);
    end

    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 12; c++) begin
        run(tp[c], ep[c]);
      end
    end

    run(1'b1, 4'b0011);
    step(1'b0, 1'b1, 1'b1, 16'd2, 16'd2, 4'b0010);
    step(1'b1, 1'b1, 1'b1, 16'd7, 16'd3, 4'b0010);
    step(1'b1, 1'b1, 1'b1, 16'd7, 16'd3, 4'b0010);
    run(1'b1, 4'b1111);
    run(1'b1, 4'b1011);
    run(1'b1, 4'b1111);
    run(1'b1, 4'b1011);

    step(1'b1, 1'b1, 1'b1, 16'd0, 16'd0, 4'b1110);
    run(1'b1, 4'b1010);
    run(1'b1, 4'b0111);
    run(1'b1, 4'b0111);
    run(1'b0, 4'b0011);
    run(1'b1, 4'b0111);

    step(1'b0, 1'b1, 1'b1, 16'd5, 16'd9, 4'b0010);
    run(1'b1, 4'b1111);
    for (int i = 0; i < 4; i++) run(1'b1, 4'b1011);
    run(1'b1, 4'b1111);
    run(1'b1, 4'b1011);

    step(1'b0, 1'b1, 1'b1, 16'd4, 16'd2, 4'b1010);
    run(1'b1, 4'b1010);
    run(1'b1, 4'b1010);
    run(1'b1, 4'b1010);
    run(1'b1, 4'b1111);
    run(1'b1, 4'b1011);
    run(1'b1, 4'b0011);
    step(1'b1, 1'b0, 1'b0, '0, '0, 4'b0001);
    step(1'b1, 1'b0, 1'b0, '0, '0, 4'b0001);
    run(1'b1, 4'b1011);
    run(1'b1, 4'b1011);
    run(1'b1, 4'b0011);
    run(1'b1, 4'b0011);
    run(1'b1, 4'b1111);
    run(1'b1, 4'b1011);

    @(negedge clk);
    #1;
    rst_n = 1'b0;
    run(1'b1, 4'b0001);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) run(1'b1, 4'b0001);

    done = 1'b1;
    repeat (50) @(posedge clk);
    $display("FAIL timeout queue=%0d want=0", sbq.size());
    $fatal(1, "bench did not drain");
  end

endmodule
